// File: rtl/demux_16b_1to2.sv
// 1-to-2 demultiplexer for 16-bit words with a small FIFO per output channel.
// sel=1 steers an accepted word to channel A, sel=0 to channel B; outputs come straight from storage.
module demux_16b_1to2 #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                in_data,
    input  logic                       sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [15:0]                out_a,
    output logic                       out_a_valid,
    input  logic                       out_a_ready,
    output logic [15:0]                out_b,
    output logic                       out_b_valid,
    input  logic                       out_b_ready,
    output logic [$clog2(DEPTH):0]     cnt_a,
    output logic [$clog2(DEPTH):0]     cnt_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   mem_a [DEPTH];
    logic [15:0]   mem_b [DEPTH];
    logic [PW-1:0] wr_a, rd_a, wr_b, rd_b;
    logic          push_a, push_b, pop_a, pop_b;

    // Only the selected channel's occupancy gates acceptance; a full channel
    // never passes a word through even while it is being popped.
    assign in_ready    = sel ? (cnt_a < FULL) : (cnt_b < FULL);
    assign push_a      = in_valid & in_ready & sel;
    assign push_b      = in_valid & in_ready & ~sel;

    assign out_a_valid = (cnt_a != '0);
    assign out_b_valid = (cnt_b != '0);
    assign pop_a       = out_a_valid & out_a_ready;
    assign pop_b       = out_b_valid & out_b_ready;

    assign out_a       = mem_a[rd_a];
    assign out_b       = mem_b[rd_b];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
            end
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
        end else begin
            if (push_a) begin
                mem_a[wr_a] <= in_data;
                wr_a        <= wr_a + PW'(1);
            end
            if (pop_a) begin
                rd_a <= rd_a + PW'(1);
            end
            case ({push_a, pop_a})
                2'b10:   cnt_a <= cnt_a + CW'(1);
                2'b01:   cnt_a <= cnt_a - CW'(1);
                default: cnt_a <= cnt_a;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_b[i] <= '0;
            end
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push_b) begin
                mem_b[wr_b] <= in_data;
                wr_b        <= wr_b + PW'(1);
            end
            if (pop_b) begin
                rd_b <= rd_b + PW'(1);
            end
            case ({push_b, pop_b})
                2'b10:   cnt_b <= cnt_b + CW'(1);
                2'b01:   cnt_b <= cnt_b - CW'(1);
                default: cnt_b <= cnt_b;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_16b_1to2.sv
// Directed bench for demux_16b_1to2 (DEPTH=2) with per-channel scoreboard queues.
// Expected words are queued when a push is accepted and compared when the bench pops them.
module tb_demux_16b_1to2;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_a;
    logic        out_a_valid;
    logic        out_a_ready;
    logic [15:0] out_b;
    logic        out_b_valid;
    logic        out_b_ready;
    logic [1:0]  cnt_a;
    logic [1:0]  cnt_b;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int          compared   = 0;
    int          mismatched = 0;

    demux_16b_1to2 #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .sel         (sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a       (out_a),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b       (out_b),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle of stimulus; entered and left 1ns after a rising edge.
    task automatic applyStimulus(input logic v, input logic s, input logic [15:0] d,
                                 input logic ra, input logic rb);
        logic exp_ready, do_pop_a, do_pop_b, accept;
        in_valid    = v;
        sel         = s;
        in_data     = d;
        out_a_ready = ra;
        out_b_ready = rb;
        #1;
        exp_ready = s ? (q_a.size() < DEPTH) : (q_b.size() < DEPTH);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        do_pop_a = ra && (q_a.size() != 0);
        do_pop_b = rb && (q_b.size() != 0);
        if (do_pop_a) checkOutput("pop_a_data", {16'd0, out_a}, {16'd0, q_a[0]});
        if (do_pop_b) checkOutput("pop_b_data", {16'd0, out_b}, {16'd0, q_b[0]});
        accept = v && exp_ready;
        @(posedge clk);
        #1;
        if (do_pop_a) void'(q_a.pop_front());
        if (do_pop_b) void'(q_b.pop_front());
        if (accept && s)  q_a.push_back(d);
        if (accept && !s) q_b.push_back(d);
        checkOutput("cnt_a", {30'd0, cnt_a}, q_a.size());
        checkOutput("cnt_b", {30'd0, cnt_b}, q_b.size());
        checkOutput("out_a_valid", {31'd0, out_a_valid}, {31'd0, q_a.size() != 0});
        checkOutput("out_b_valid", {31'd0, out_b_valid}, {31'd0, q_b.size() != 0});
        if (q_a.size() != 0) checkOutput("head_a", {16'd0, out_a}, {16'd0, q_a[0]});
        if (q_b.size() != 0) checkOutput("head_b", {16'd0, out_b}, {16'd0, q_b[0]});
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b1;
        sel         = 1'b1;
        in_data     = 16'h7777;
        out_a_ready = 1'b0;
        out_b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cnt_a", {30'd0, cnt_a}, 32'd0);
        checkOutput("rst_cnt_b", {30'd0, cnt_b}, 32'd0);
        checkOutput("rst_out_a", {16'd0, out_a}, 32'h0);
        checkOutput("rst_out_b", {16'd0, out_b}, 32'h0);
        checkOutput("rst_valid_a", {31'd0, out_a_valid}, 32'd0);
        checkOutput("rst_valid_b", {31'd0, out_b_valid}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Single word to A appears after one edge
        applyStimulus(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0);
        checkOutput("a5a5_out_a", {16'd0, out_a}, 32'hA5A5);
        checkOutput("a5a5_cnt_a", {30'd0, cnt_a}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill B, then check per-channel ready and a refused third push
        applyStimulus(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        checkOutput("full_cnt_b", {30'd0, cnt_b}, 32'd2);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0099, 1'b0, 1'b0);

        // Full B: pop with a push attempt, push refused
        applyStimulus(1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b1);
        checkOutput("popfull_cnt_b", {30'd0, cnt_b}, 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Push A while popping B
        applyStimulus(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h2222, 1'b0, 1'b1);
        checkOutput("cross_cnt_a", {30'd0, cnt_a}, 32'd1);
        checkOutput("cross_cnt_b", {30'd0, cnt_b}, 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Five words through A with consumer ready: pointer wrap
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(i), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset between edges with A full
        applyStimulus(1'b1, 1'b1, 16'h00C1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h00C2, 1'b0, 1'b0);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_cnt_a", {30'd0, cnt_a}, 32'd0);
        checkOutput("async_out_a", {16'd0, out_a}, 32'h0);
        checkOutput("async_valid_a", {31'd0, out_a_valid}, 32'd0);
        q_a.delete();
        q_b.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        checkOutput("beef_out_a", {16'd0, out_a}, 32'hBEEF);
        applyStimulus(1'b1, 1'b1, 16'h0042, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
